// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM BIST initiator.
// Holds the FSM state set and the fixed 8-entry test pattern list.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int PATTERN_COUNT = 8;

    localparam logic [3:0] PAT_0 = 4'h0;
    localparam logic [3:0] PAT_1 = 4'hF;
    localparam logic [3:0] PAT_2 = 4'h5;
    localparam logic [3:0] PAT_3 = 4'hA;
    localparam logic [3:0] PAT_4 = 4'h1;
    localparam logic [3:0] PAT_5 = 4'h2;
    localparam logic [3:0] PAT_6 = 4'h4;
    localparam logic [3:0] PAT_7 = 4'h8;

endpackage

// File: rtl/sram_bist_ctrl_if.sv
// Command/response port of the 4-bit single-word SRAM test macro.
// master = BIST initiator (drives strobe and write data), slave = macro.
interface sram_bist_ctrl_if;
    logic       mem_enable;
    logic       mem_rnw;
    logic [3:0] mem_wdata;
    logic       mem_ready;
    logic [3:0] mem_rdata;

    modport master (
        output mem_enable, mem_rnw, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_enable, mem_rnw, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/sram_bist_pattern_rom.sv
// Pattern index to 4-bit test pattern lookup.
// Purely combinational, zero latency, no flow control.
module sram_bist_pattern_rom
    import sram_bist_pkg::*;
(
    input  logic [2:0] idx,
    output logic [3:0] pattern
);

    always_comb begin
        pattern = PAT_0;
        case (idx)
            3'd0: pattern = PAT_0;
            3'd1: pattern = PAT_1;
            3'd2: pattern = PAT_2;
            3'd3: pattern = PAT_3;
            3'd4: pattern = PAT_4;
            3'd5: pattern = PAT_5;
            3'd6: pattern = PAT_6;
            3'd7: pattern = PAT_7;
            default: pattern = PAT_0;
        endcase
    end

endmodule

// File: rtl/sram_bist_ctrl.sv
// SRAM BIST initiator: write/read-compare of 8 patterns, NUM_PASSES times, reporting pass/fail.
// 4 cycles per operation with an ideal macro; stalls on mem_ready=0, aborting after TIMEOUT cycles.
module sram_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int NUM_PASSES = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [2:0]             fail_index,
    output logic [3:0]             fail_data,
    sram_bist_ctrl_if.master       mem
);

    localparam int PC_W = $clog2(NUM_PASSES + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [PC_W-1:0] LAST_PASS = PC_W'(NUM_PASSES - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_PREP  = ST_PREP;
    localparam logic [2:0] S_ISSUE = ST_ISSUE;
    localparam logic [2:0] S_HOLD  = ST_HOLD;
    localparam logic [2:0] S_WAIT  = ST_WAIT;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0]      state;
    logic [2:0]      idx;
    logic            phase;
    logic [PC_W-1:0] pass_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [2:0]      rom_idx;
    logic [3:0]      rom_pat;
    logic            waiting;

    // Pattern for the operation about to be prepared; idx+1 wraps 7->0 for the next pass.
    always_comb begin
        rom_idx = 3'd0;
        if (state == S_WAIT) begin
            rom_idx = phase ? idx + 3'd1 : idx;
        end
    end

    assign waiting = (state == S_PREP) || (state == S_WAIT);

    sram_bist_pattern_rom u_rom (
        .idx     (rom_idx),
        .pattern (rom_pat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= 3'd0;
            phase          <= 1'b0;
            pass_cnt       <= '0;
            to_cnt         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            fail_index     <= 3'd0;
            fail_data      <= 4'd0;
            mem.mem_enable <= 1'b0;
            mem.mem_rnw    <= 1'b0;
            mem.mem_wdata  <= 4'd0;
        end else if (waiting && !mem.mem_ready) begin
            if (to_cnt == TO_LAST) begin
                state   <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                fail    <= 1'b1;
                timeout <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_PREP;
                        idx           <= 3'd0;
                        phase         <= 1'b0;
                        pass_cnt      <= '0;
                        to_cnt        <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        fail          <= 1'b0;
                        timeout       <= 1'b0;
                        fail_index    <= 3'd0;
                        fail_data     <= 4'd0;
                        mem.mem_rnw   <= 1'b0;
                        mem.mem_wdata <= rom_pat;
                    end
                end
                S_PREP: begin
                    state          <= S_ISSUE;
                    mem.mem_enable <= 1'b1;
                    to_cnt         <= '0;
                end
                S_ISSUE: begin
                    state          <= S_HOLD;
                    mem.mem_enable <= 1'b0;
                end
                S_HOLD: state <= S_WAIT;
                S_WAIT: begin
                    to_cnt <= '0;
                    // mem_wdata still holds this index's pattern during the read
                    if (!phase) begin
                        state         <= S_PREP;
                        phase         <= 1'b1;
                        mem.mem_rnw   <= 1'b1;
                        mem.mem_wdata <= rom_pat;
                    end else if (mem.mem_rdata != mem.mem_wdata) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        fail       <= 1'b1;
                        fail_index <= idx;
                        fail_data  <= mem.mem_rdata;
                    end else if (idx == 3'd7 && pass_cnt == LAST_PASS) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        state         <= S_PREP;
                        phase         <= 1'b0;
                        idx           <= idx + 3'd1;
                        mem.mem_rnw   <= 1'b0;
                        mem.mem_wdata <= rom_pat;
                        if (idx == 3'd7) begin
                            pass_cnt <= pass_cnt + PC_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: two instances (1 and 2 passes) against a behavioural SRAM macro
// with injectable stuck-at faults and a tied-low ready; results checked by a done-triggered scoreboard.
module tb_sram_bist_ctrl;

    typedef struct {
        int         g;
        int         done_cyc;
        logic       pass_e;
        logic       fail_e;
        logic       tmo_e;
        logic [2:0] fidx;
        logic [3:0] fdat;
        int         en_cnt;
        int         en_base;
    } exp_t;

    localparam int TMO = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [2] = '{1'b1, 1'b1};
    logic       start_s [2] = '{1'b0, 1'b0};
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       pass_s  [2];
    logic       fail_s  [2];
    logic       tmo_s   [2];
    logic [2:0] fidx_s  [2];
    logic [3:0] fdat_s  [2];

    logic       en      [2];
    logic       rnw     [2];
    logic [3:0] wd      [2];
    logic       rdy     [2];
    logic [3:0] rd      [2] = '{4'd0, 4'd0};
    logic [3:0] word    [2] = '{4'd0, 4'd0};
    logic       mbusy   [2] = '{1'b0, 1'b0};
    logic [3:0] or_m    [2] = '{4'd0, 4'd0};
    logic [3:0] and_m   [2] = '{4'hF, 4'hF};
    logic       tie     [2] = '{1'b0, 1'b0};

    sram_bist_ctrl_if m0 ();
    sram_bist_ctrl_if m1 ();

    assign en[0]  = m0.mem_enable;
    assign rnw[0] = m0.mem_rnw;
    assign wd[0]  = m0.mem_wdata;
    assign m0.mem_ready = rdy[0];
    assign m0.mem_rdata = rd[0];
    assign en[1]  = m1.mem_enable;
    assign rnw[1] = m1.mem_rnw;
    assign wd[1]  = m1.mem_wdata;
    assign m1.mem_ready = rdy[1];
    assign m1.mem_rdata = rd[1];

    assign rdy[0] = !mbusy[0] && !tie[0];
    assign rdy[1] = !mbusy[1] && !tie[1];

    sram_bist_ctrl #(.NUM_PASSES(1), .TIMEOUT(TMO)) dut0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .fail(fail_s[0]), .timeout(tmo_s[0]), .fail_index(fidx_s[0]),
        .fail_data(fdat_s[0]), .mem(m0)
    );

    sram_bist_ctrl #(.NUM_PASSES(2), .TIMEOUT(TMO)) dut1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .fail(fail_s[1]), .timeout(tmo_s[1]), .fail_index(fidx_s[1]),
        .fail_data(fdat_s[1]), .mem(m1)
    );

    // Macro: one busy cycle after the strobe, then executes and returns registered read data.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mbusy[g]) begin
                mbusy[g] <= 1'b0;
                if (rnw[g]) rd[g] <= (word[g] | or_m[g]) & and_m[g];
                else        word[g] <= wd[g];
            end else if (en[g]) begin
                mbusy[g] <= 1'b1;
            end
        end
    end

    int cyc = 0;
    int en_total [2] = '{0, 0};
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++)
            if (en[g]) en_total[g] <= en_total[g] + 1;
    end

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq [$];

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: actual %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference: walk passes and patterns, first stored-value corruption decides the outcome.
    function automatic exp_t ref_run(input int g, input int passes, input logic [3:0] orm,
                                     input logic [3:0] andm, input logic t0, input int s);
        logic [3:0] pats [8] = '{4'h0, 4'hF, 4'h5, 4'hA, 4'h1, 4'h2, 4'h4, 4'h8};
        exp_t e;
        logic [3:0] r;
        int ops;
        e.g = g; e.pass_e = 1'b0; e.fail_e = 1'b0; e.tmo_e = 1'b0;
        e.fidx = 3'd0; e.fdat = 4'd0; e.en_base = 0; e.en_cnt = 0;
        if (t0) begin
            e.fail_e = 1'b1; e.tmo_e = 1'b1;
            e.done_cyc = s + TMO + 1;
            return e;
        end
        ops = 0;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < 8; i++) begin
                ops += 2;
                r = (pats[i] | orm) & andm;
                if (r != pats[i]) begin
                    e.fail_e = 1'b1; e.fidx = 3'(i); e.fdat = r;
                    e.en_cnt = ops; e.done_cyc = s + 4 * ops + 1;
                    return e;
                end
            end
        end
        e.pass_e = 1'b1; e.en_cnt = ops; e.done_cyc = s + 4 * ops + 1;
        return e;
    endfunction

    // Monitor: every rising done is matched against the oldest expectation.
    logic done_q [2] = '{1'b0, 1'b0};
    logic busy_q [2] = '{1'b0, 1'b0};
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            if (done_s[g] && !done_q[g]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", sbq.size(), 1);
                end else begin
                    e = sbq.pop_front();
                    chk("instance", g, e.g);
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("pass", int'(pass_s[g]), int'(e.pass_e));
                    chk("fail", int'(fail_s[g]), int'(e.fail_e));
                    chk("timeout", int'(tmo_s[g]), int'(e.tmo_e));
                    chk("fail_index", int'(fidx_s[g]), int'(e.fidx));
                    chk("fail_data", int'(fdat_s[g]), int'(e.fdat));
                    chk("enable_pulses", en_total[g] - e.en_base, e.en_cnt);
                    chk("busy_at_done", int'(busy_s[g]), 0);
                    chk("busy_before_done", int'(busy_q[g]), 1);
                end
            end
            done_q[g] = done_s[g];
            busy_q[g] = busy_s[g];
        end
    end

    task automatic chk_zero(input int g);
        chk("rst_busy", int'(busy_s[g]), 0);
        chk("rst_done", int'(done_s[g]), 0);
        chk("rst_pass", int'(pass_s[g]), 0);
        chk("rst_fail", int'(fail_s[g]), 0);
        chk("rst_timeout", int'(tmo_s[g]), 0);
        chk("rst_fail_index", int'(fidx_s[g]), 0);
        chk("rst_fail_data", int'(fdat_s[g]), 0);
        chk("rst_mem_enable", int'(en[g]), 0);
        chk("rst_mem_rnw", int'(rnw[g]), 0);
        chk("rst_mem_wdata", int'(wd[g]), 0);
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 of the run.
    task automatic launch(input int g, input logic [3:0] orm, input logic [3:0] andm,
                          input logic t0, input bit push);
        exp_t e;
        or_m[g] = orm; and_m[g] = andm; tie[g] = t0;
        e = ref_run(g, (g == 0) ? 1 : 2, orm, andm, t0, cyc);
        e.en_base = en_total[g];
        if (push) sbq.push_back(e);
        start_s[g] = 1'b1;
        @(negedge clk);
        start_s[g] = 1'b0;
        chk("start_busy", int'(busy_s[g]), 1);
        chk("start_done_clr", int'(done_s[g]), 0);
        chk("start_pass_clr", int'(pass_s[g]), 0);
        chk("start_fail_clr", int'(fail_s[g]), 0);
        chk("start_timeout_clr", int'(tmo_s[g]), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", sbq.size(), 0);
        sbq.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int g;
        int kind;
        int b;
        logic [3:0] orm;
        logic [3:0] andm;
        logic t0;

        repeat (3) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        @(negedge clk);

        launch(0, 4'h0, 4'hF, 1'b0, 1'b1); wait_done();
        launch(0, 4'h1, 4'hF, 1'b0, 1'b1); wait_done();
        launch(0, 4'h0, 4'h7, 1'b0, 1'b1); wait_done();
        launch(0, 4'h0, 4'hF, 1'b1, 1'b1); wait_done();

        // Reset during HOLD of operation 5 (read of index 2)
        launch(0, 4'h0, 4'hF, 1'b0, 1'b0);
        repeat (22) @(negedge clk);
        chk("hold_busy", int'(busy_s[0]), 1);
        chk("hold_rnw", int'(rnw[0]), 1);
        rst_s[0] = 1'b1;
        #1;
        chk_zero(0);
        @(negedge clk);
        rst_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        launch(0, 4'h0, 4'hF, 1'b0, 1'b1); wait_done();

        // Reset during ISSUE of operation 2: strobe must drop at once
        launch(0, 4'h0, 4'hF, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        chk("issue_enable", int'(en[0]), 1);
        rst_s[0] = 1'b1;
        #1;
        chk("issue_enable_drop", int'(en[0]), 0);
        chk("issue_busy_drop", int'(busy_s[0]), 0);
        @(negedge clk);
        rst_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        launch(0, 4'h0, 4'hF, 1'b0, 1'b1); wait_done();

        // Two passes; start while busy is ignored, start in DONE reruns
        launch(1, 4'h0, 4'hF, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        start_s[1] = 1'b1;
        @(negedge clk);
        start_s[1] = 1'b0;
        wait_done();
        launch(1, 4'h0, 4'hF, 1'b0, 1'b1); wait_done();

        for (int k = 0; k < 14; k++) begin
            g    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 4));
            b    = int'($urandom_range(0, 3));
            orm  = 4'h0;
            andm = 4'hF;
            t0   = 1'b0;
            case (kind)
                1: orm  = 4'(1 << b);
                2: andm = ~4'(1 << b);
                3: t0   = 1'b1;
                default: ;
            endcase
            repeat ($urandom_range(0, 5)) @(negedge clk);
            launch(g, orm, andm, t0, 1'b1);
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
